// File: rtl/ram_cmd_ctrl.sv
// UART command front-end for a 128 x 32 RAM.
// A write is a command byte plus four MSB-first data bytes. A read returns four MSB-first bytes.
module ram_cmd_ctrl #(
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [6:0]  ram_addr,
  output logic [31:0] ram_data_in,
  output logic        ram_write_en,
  output logic        ram_read_en,
  input  logic [31:0] ram_data_out,
  output logic        busy
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DATA, S_WR_COMMIT, S_RD_REQ, S_RD_WAIT, S_TX_SEND, S_TX_GAP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [6:0]         r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_shift;
  logic [1:0]         r_byte;
  logic [TMO_W-1:0]   r_tmo;
  logic               w_tmo_hit;

  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (rx_valid) w_next = rx_data[7] ? S_WR_DATA : S_RD_REQ;
      S_WR_DATA: begin
        if (rx_valid) begin
          if (r_byte == 2'd3) w_next = S_WR_COMMIT;
        end else if (w_tmo_hit) begin
          w_next = S_IDLE;
        end
      end
      S_WR_COMMIT: w_next = S_IDLE;
      S_RD_REQ:    w_next = S_RD_WAIT;
      S_RD_WAIT:   w_next = S_TX_SEND;
      S_TX_SEND:   if (!tx_busy) w_next = S_TX_GAP;
      S_TX_GAP:    w_next = (r_byte == 2'd3) ? S_IDLE : S_TX_SEND;
      default:     w_next = S_IDLE;
    endcase
  end

  // r_byte counts received data bytes while writing and transmitted bytes while reading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_addr <= rx_data[6:0];
            r_byte <= '0;
            r_tmo  <= '0;
          end
        end
        S_WR_DATA: begin
          if (rx_valid) begin
            r_wdata <= {r_wdata[23:0], rx_data};
            r_byte  <= r_byte + 2'd1;
            r_tmo   <= '0;
          end else if (w_tmo_hit) begin
            r_wdata <= '0;
            r_tmo   <= '0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_RD_WAIT: begin
          r_shift <= ram_data_out;
          r_byte  <= '0;
        end
        S_TX_GAP: begin
          r_shift <= {r_shift[23:0], 8'h00};
          r_byte  <= r_byte + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign ram_addr     = r_addr;
  assign ram_data_in  = r_wdata;
  assign tx_data      = r_shift[31:24];
  assign ram_write_en = (r_state == S_WR_COMMIT);
  assign ram_read_en  = (r_state == S_RD_REQ);
  assign tx_start     = (r_state == S_TX_SEND) && !tx_busy;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Directed self-checking bench for ram_cmd_ctrl.
// It includes a registered RAM model and a UART transmitter model that stays busy for a fixed time.
module tb_ram_cmd_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [6:0]  ram_addr;
  logic [31:0] ram_data_in;
  logic        ram_write_en;
  logic        ram_read_en;
  logic [31:0] ram_data_out = 32'h0;
  logic        busy;

  ram_cmd_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_write_en(ram_write_en),
    .ram_read_en(ram_read_en), .ram_data_out(ram_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:127];
  int          wr_cnt = 0, rd_cnt = 0, viol = 0;
  logic [6:0]  last_wr_addr, last_rd_addr, rd_addr_l;
  logic [31:0] last_wr_data;
  logic        rd_pend = 1'b0, tx_pend = 1'b0, prev_tx_start = 1'b0;
  logic [7:0]  txq [$];

  // Bus monitor. It samples on the falling edge.
  always @(negedge clk) begin
    if (ram_write_en) begin
      wr_cnt++; last_wr_addr = ram_addr; last_wr_data = ram_data_in;
      mem[ram_addr] = ram_data_in;
    end
    if (ram_read_en) begin
      rd_cnt++; last_rd_addr = ram_addr; rd_addr_l = ram_addr; rd_pend = 1'b1;
    end
    if (ram_write_en && ram_read_en) viol++;
    if (tx_start) begin
      if (prev_tx_start || tx_busy) viol++;
      txq.push_back(tx_data);
      tx_pend = 1'b1;
    end
    prev_tx_start = tx_start;
  end

  // RAM read data and the transmitter busy model. Both update 1 time unit after the rising edge.
  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rd_pend) begin ram_data_out = mem[rd_addr_l]; rd_pend = 1'b0; end
      if (tx_pend) begin tx_busy = 1'b1; bcnt = 6; tx_pend = 1'b0; end
      else if (bcnt > 0) begin bcnt--; if (bcnt == 0) tx_busy = 1'b0; end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // The caller must be 1 time unit after a rising edge. The byte occupies exactly one cycle.
  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 400 && txq.size() < n; i++) begin @(posedge clk); #1; end
    tick(2);
  endtask

  task automatic test_reset;
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0h want 0", busy); end
    n_cmp++; if (ram_write_en !== 1'b0 || ram_read_en !== 1'b0) begin n_err++; $display("FAIL reset_ram_en: got %0b%0b want 00", ram_write_en, ram_read_en); end
    n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %0h want 0", tx_start); end
    n_cmp++; if (ram_addr !== 7'h0) begin n_err++; $display("FAIL reset_addr: got %0h want 0", ram_addr); end
    n_cmp++; if (ram_data_in !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %0h want 0", ram_data_in); end
    n_cmp++; if (tx_data !== 8'h0) begin n_err++; $display("FAIL reset_tx_data: got %0h want 0", tx_data); end
    @(posedge clk); #1; rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_write;
    send(8'h85); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    n_cmp++; if (ram_write_en !== 1'b1) begin n_err++; $display("FAIL wr_latency: write_en got %0h want 1", ram_write_en); end
    n_cmp++; if (ram_addr !== 7'h05) begin n_err++; $display("FAIL wr_addr: got %0h want 05", ram_addr); end
    n_cmp++; if (ram_data_in !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_data: got %0h want deadbeef", ram_data_in); end
    tick(1);
    n_cmp++; if (ram_write_en !== 1'b0) begin n_err++; $display("FAIL wr_one_cycle: write_en got %0h want 0", ram_write_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_idle: busy got %0h want 0", busy); end
    tick(1);
    n_cmp++; if (wr_cnt !== 1) begin n_err++; $display("FAIL wr_count: got %0d want 1", wr_cnt); end
  endtask

  task automatic test_read;
    txq.delete();
    send(8'h05);
    wait_tx(4);
    tick(4);
    n_cmp++; if (rd_cnt !== 1) begin n_err++; $display("FAIL rd_count: got %0d want 1", rd_cnt); end
    n_cmp++; if (last_rd_addr !== 7'h05) begin n_err++; $display("FAIL rd_addr: got %0h want 05", last_rd_addr); end
    n_cmp++; if (txq.size() !== 4) begin n_err++; $display("FAIL rd_tx_count: got %0d want 4", txq.size()); end
    else begin
      n_cmp++; if ({txq[0], txq[1], txq[2], txq[3]} !== 32'hDEADBEEF)
        begin n_err++; $display("FAIL rd_tx_bytes: got %h%h%h%h want deadbeef", txq[0], txq[1], txq[2], txq[3]); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_idle: busy got %0h want 0", busy); end
  endtask

  task automatic test_timeout;
    int wr0;
    wr0 = wr_cnt;
    send(8'h83); send(8'h11); send(8'h22);
    tick(15);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL tmo_early: busy got %0h want 1", busy); end
    tick(1);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_expire: busy got %0h want 0", busy); end
    n_cmp++; if (wr_cnt !== wr0) begin n_err++; $display("FAIL tmo_no_write: got %0d want %0d", wr_cnt, wr0); end
    txq.delete();
    tick(1);
    send(8'h03);
    wait_tx(4);
    tick(4);
    n_cmp++; if (txq.size() !== 4) begin n_err++; $display("FAIL tmo_read_count: got %0d want 4", txq.size()); end
    else begin
      n_cmp++; if ({txq[0], txq[1], txq[2], txq[3]} !== 32'h01020304)
        begin n_err++; $display("FAIL tmo_read_bytes: got %h%h%h%h want 01020304", txq[0], txq[1], txq[2], txq[3]); end
    end
  endtask

  task automatic test_reset_mid_write;
    int wr0;
    wr0 = wr_cnt;
    send(8'hFF); send(8'h01); send(8'h02);
    rst_n = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %0h want 0", busy); end
    n_cmp++; if (ram_addr !== 7'h0 || ram_data_in !== 32'h0) begin n_err++; $display("FAIL rst_mid_regs: addr %0h data %0h want 0 0", ram_addr, ram_data_in); end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    n_cmp++; if (wr_cnt !== wr0) begin n_err++; $display("FAIL rst_mid_no_write: got %0d want %0d", wr_cnt, wr0); end
    send(8'hFF); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    tick(2);
    n_cmp++; if (wr_cnt !== wr0 + 1 || last_wr_addr !== 7'h7F || last_wr_data !== 32'h11223344)
      begin n_err++; $display("FAIL rst_mid_rewrite: cnt %0d addr %0h data %0h want %0d 7f 11223344", wr_cnt, last_wr_addr, last_wr_data, wr0 + 1); end
  endtask

  task automatic test_drop_during_read;
    int rd0;
    rd0 = rd_cnt;
    txq.delete();
    send(8'h05);
    for (int i = 0; i < 100 && txq.size() < 1; i++) tick(1);
    tick(2);
    send(8'hAA);
    wait_tx(4);
    tick(20);
    n_cmp++; if (txq.size() !== 4) begin n_err++; $display("FAIL drop_tx_count: got %0d want 4", txq.size()); end
    else begin
      n_cmp++; if ({txq[0], txq[1], txq[2], txq[3]} !== 32'hDEADBEEF)
        begin n_err++; $display("FAIL drop_tx_bytes: got %h%h%h%h want deadbeef", txq[0], txq[1], txq[2], txq[3]); end
    end
    n_cmp++; if (rd_cnt !== rd0 + 1) begin n_err++; $display("FAIL drop_rd_count: got %0d want %0d", rd_cnt, rd0 + 1); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle: busy got %0h want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    send(8'h90); send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
    send(8'h10);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_dropped_cmd: busy got %0h want 0", busy); end
    tick(10);
    n_cmp++; if (rd_cnt !== rd0) begin n_err++; $display("FAIL b2b_no_read: got %0d want %0d", rd_cnt, rd0); end
    n_cmp++; if (wr_cnt !== wr0 + 1 || last_wr_addr !== 7'h10 || last_wr_data !== 32'hCAFEBABE)
      begin n_err++; $display("FAIL b2b_write: cnt %0d addr %0h data %0h want %0d 10 cafebabe", wr_cnt, last_wr_addr, last_wr_data, wr0 + 1); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[3] = 32'h01020304;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_reset_mid_write();
    test_drop_during_read();
    test_back_to_back();
    n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL protocol_violations: got %0d want 0", viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: sim time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/ram_cmd_ctrl.md
RAM_CMD_CTRL -- requirements
Module: ram_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 100000, giving the inter-byte timeout in clk cycles during write-data collection.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port rx_data  input  8  received UART byte.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-006 SHALL have port tx_busy  input  1  UART transmitter busy; asserted no later than 1 cycle after tx_start.
REQ-007 SHALL have port tx_data  output  8  byte to transmit, held stable while tx_start=1.
REQ-008 SHALL have port tx_start  output  1  one-cycle transmit request.
REQ-009 SHALL have port ram_addr  output  7  RAM word address.
REQ-010 SHALL have port ram_data_in  output  32  RAM write data.
REQ-011 SHALL have port ram_write_en  output  1  RAM write strobe.
REQ-012 SHALL have port ram_read_en  output  1  RAM read strobe.
REQ-013 SHALL have port ram_data_out  input  32  RAM read data, registered, valid the cycle after ram_read_en.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL decode a command byte accepted in IDLE: bit7=1 is write, bit7=0 is read; bits6:0 are the address, latched into ram_addr.
REQ-016 SHALL implement states IDLE, WR_DATA, WR_COMMIT, RD_REQ, RD_WAIT, TX_SEND, TX_GAP.
REQ-017 IDLE: rx_valid with bit7=1 -> WR_DATA with byte count 0; rx_valid with bit7=0 -> RD_REQ; otherwise stay.
REQ-018 WR_DATA: each rx_valid shifts rx_data into ram_data_in MSB-first (first byte lands in bits31:24); on the 4th byte -> WR_COMMIT.
REQ-019 WR_COMMIT: ram_write_en=1 for exactly one cycle with the latched ram_addr and assembled ram_data_in, then -> IDLE.
REQ-020 Write latency: ram_write_en SHALL assert the cycle after the cycle carrying the 4th rx_valid.
REQ-021 WR_DATA: the inter-byte counter SHALL reset on every rx_valid; reaching TIMEOUT cycles without rx_valid -> IDLE with no write and the partial word discarded.
REQ-022 RD_REQ: ram_read_en=1 for exactly one cycle, then -> RD_WAIT.
REQ-023 RD_WAIT: capture ram_data_out into the 32-bit transmit shift register, set byte index 0, then -> TX_SEND.
REQ-024 TX_SEND: when tx_busy=0, pulse tx_start for one cycle with tx_data = shift register bits31:24, then -> TX_GAP; while tx_busy=1, wait.
REQ-025 TX_GAP: single cycle, tx_busy ignored; shift register shifts left 8 bits; if 4 bytes have been sent -> IDLE, else -> TX_SEND.
REQ-026 The read response SHALL be exactly 4 tx_start pulses, MSB byte first.
REQ-027 rx_valid in RD_REQ, RD_WAIT, TX_SEND, TX_GAP or WR_COMMIT SHALL be ignored and dropped.
REQ-028 ram_write_en and ram_read_en SHALL never be high in the same cycle; tx_start SHALL never be high in two consecutive cycles.
REQ-029 A command byte arriving in the same cycle the FSM returns to IDLE SHALL be dropped; it is accepted only while the state is already IDLE.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE and clear ram_addr, ram_data_in, tx_data, shift register, byte and timeout counters to 0, and force ram_write_en, ram_read_en, tx_start and busy to 0.
REQ-031 Reset mid-operation SHALL abort any write without a RAM write and any read response without further tx_start; operation resumes from IDLE on the first clk edge after rst_n=1.

Verification
REQ-032 Write: bytes 0x85,0xDE,0xAD,0xBE,0xEF -> one ram_write_en pulse with addr=0x05, data=0xDEADBEEF, one cycle after the 5th rx_valid.
REQ-033 Read: after REQ-032, byte 0x05 -> one ram_read_en pulse with addr=0x05, then tx bytes 0xDE,0xAD,0xBE,0xEF in order, each tx_start issued only while tx_busy=0.
REQ-034 Timeout with TIMEOUT=16: bytes 0x83,0x11,0x22, then idle for 16 cycles -> busy falls, no ram_write_en; a following 0x03 read then proceeds normally.
REQ-035 Reset mid-write: 0xFF,0x01,0x02, then rst_n low for 2 cycles -> all outputs 0, no ram_write_en; a later full write to addr 0x7F succeeds.
REQ-036 Drop during read: rx_valid 0xAA issued during TX_SEND -> ignored, exactly 4 tx_start pulses, no extra command decoded.
